weight_sram_packer: RTL and testbench

Downstream of the AXI-Stream input stage. Consumes its per-byte SRAM write stream (write_enable, write_address, write_data, data_type) and packs consecutive bytes into PACK-lane wide words for the op weight SRAM banks. Emits one wide write with a byte strobe per word. Raises sticky per-bank "written" flags and an error flag for the control path.

---
 rtl/weight_sram_packer.sv | 227 ++++++++++++++++++++++
 tb/tb_weight_sram_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_sram_packer.sv
`default_nettype none
// ============================================================================
// Module   : weight_sram_packer
// Brief    : Packs the per-byte SRAM write stream from the AXI-Stream input
//            stage into PACK-lane words for the op weight SRAM banks. One
//            wide write with a byte strobe is emitted per word. Sticky
//            per-bank "written" flags and a sticky error flag are provided.
// Options  : PACKER_ZERO_FILL_EN - unwritten lanes are emitted as zero and
//            the strobe is forced all-ones (for banks without byte enables).
// Revision : 1.0 - initial release
// ============================================================================
module weight_sram_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK           = 8,
  parameter int MAX_ADDR_WIDTH = 13,
  parameter int NUM_BANKS      = 7,
  localparam int c_LW          = $clog2(PACK),
  localparam int c_WAW         = MAX_ADDR_WIDTH - c_LW,
  localparam int c_WW          = DATA_WIDTH * PACK
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      init,
  input  logic                      write_enable_i,
  input  logic [MAX_ADDR_WIDTH-1:0] write_address_i,
  input  logic [DATA_WIDTH-1:0]     write_data_i,
  input  logic [2:0]                data_type_i,
  input  logic                      flush_i,
  output logic                      sram_we_o,
  output logic [2:0]                sram_bank_o,
  output logic [c_WAW-1:0]          sram_addr_o,
  output logic [c_WW-1:0]           sram_wdata_o,
  output logic [PACK-1:0]           sram_wstrb_o,
  output logic [NUM_BANKS-1:0]      bank_written_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam logic [3:0] c_NUM_BANKS = 4'(NUM_BANKS);

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_OPEN       = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             tag_bank_q, tag_bank_d;
  logic [c_WAW-1:0]       tag_addr_q, tag_addr_d;
  logic [c_WW-1:0]        buf_q, buf_d;
  logic [PACK-1:0]        strb_q, strb_d;
  logic                   err_q, err_d;
  logic [NUM_BANKS-1:0]   bank_written_q, bank_written_d;

  logic                   sram_we_q;
  logic [2:0]             sram_bank_q;
  logic [c_WAW-1:0]       sram_addr_q;
  logic [c_WW-1:0]        sram_wdata_q;
  logic [PACK-1:0]        sram_wstrb_q;

  logic [c_LW-1:0]        w_lane;
  logic [c_WAW-1:0]       w_waddr;
  logic                   w_id_bad;
  logic                   w_accept;
  logic                   w_match;
  logic                   w_flush_eff;
  logic                   w_emit;
  logic [2:0]             w_emit_bank;
  logic [c_WAW-1:0]       w_emit_addr;
  logic [c_WW-1:0]        w_emit_buf;
  logic [PACK-1:0]        w_emit_strb;
  logic [c_WW-1:0]        w_out_data;
  logic [PACK-1:0]        w_out_strb;

  assign w_lane      = write_address_i[c_LW-1:0];
  assign w_waddr     = write_address_i[MAX_ADDR_WIDTH-1:c_LW];
  assign w_id_bad    = write_enable_i && ({1'b0, data_type_i} > c_NUM_BANKS);
  assign w_accept    = write_enable_i && (data_type_i != 3'd0) && !w_id_bad;
  assign w_match     = (state_q != ST_EMPTY) && (tag_bank_q == data_type_i) &&
                       (tag_addr_q == w_waddr);
  // A pending flush behaves exactly like a flush request on the current word.
  assign w_flush_eff = flush_i || (state_q == ST_FLUSH_PEND);

  // Word assembly: merge/open words and decide whether a word leaves this edge.
  always_comb begin
    state_d     = state_q;
    tag_bank_d  = tag_bank_q;
    tag_addr_d  = tag_addr_q;
    buf_d       = buf_q;
    strb_d      = strb_q;
    err_d       = err_q;
    w_emit      = 1'b0;
    w_emit_bank = tag_bank_q;
    w_emit_addr = tag_addr_q;
    w_emit_buf  = buf_q;
    w_emit_strb = strb_q;

    if (w_id_bad) begin
      err_d = 1'b1;
    end

    if (w_accept && !w_match) begin
      // Any open word leaves with its old contents while the new one opens.
      w_emit     = (state_q != ST_EMPTY);
      tag_bank_d = data_type_i;
      tag_addr_d = w_waddr;
      buf_d[w_lane*DATA_WIDTH +: DATA_WIDTH] = write_data_i;
      strb_d         = '0;
      strb_d[w_lane] = 1'b1;
      if ((state_q == ST_EMPTY) && flush_i) begin
        // Nothing was open, so the single-byte word can leave right away.
        w_emit      = 1'b1;
        w_emit_bank = data_type_i;
        w_emit_addr = w_waddr;
        w_emit_buf  = buf_d;
        w_emit_strb = strb_d;
        strb_d      = '0;
        state_d     = ST_EMPTY;
      end else begin
        state_d = flush_i ? ST_FLUSH_PEND : ST_OPEN;
      end
    end else if (w_accept) begin
      if (strb_q[w_lane]) begin
        err_d = 1'b1;
      end
      buf_d[w_lane*DATA_WIDTH +: DATA_WIDTH] = write_data_i;
      strb_d[w_lane] = 1'b1;
      if ((&strb_d) || w_flush_eff) begin
        w_emit      = 1'b1;
        w_emit_buf  = buf_d;
        w_emit_strb = strb_d;
        strb_d      = '0;
        state_d     = ST_EMPTY;
      end
    end else if ((state_q != ST_EMPTY) && w_flush_eff) begin
      w_emit  = 1'b1;
      strb_d  = '0;
      state_d = ST_EMPTY;
    end
  end

`ifdef PACKER_ZERO_FILL_EN
  for (genvar k = 0; k < PACK; k++) begin : g_zero_fill
    assign w_out_data[k*DATA_WIDTH +: DATA_WIDTH] =
      w_emit_strb[k] ? w_emit_buf[k*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  assign w_out_strb = '1;
`else
  assign w_out_data = w_emit_buf;
  assign w_out_strb = w_emit_strb;
`endif

  // Sticky bank flag for the bank receiving a word on this edge.
  always_comb begin
    bank_written_d = bank_written_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_emit && (w_emit_bank == 3'(b + 1))) begin
        bank_written_d[b] = 1'b1;
      end
    end
  end

  // Packer state, open-word buffer and sticky flags.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q        <= ST_EMPTY;
      tag_bank_q     <= '0;
      tag_addr_q     <= '0;
      buf_q          <= '0;
      strb_q         <= '0;
      err_q          <= 1'b0;
      bank_written_q <= '0;
    end else if (init) begin
      state_q        <= ST_EMPTY;
      tag_bank_q     <= '0;
      tag_addr_q     <= '0;
      buf_q          <= '0;
      strb_q         <= '0;
      err_q          <= 1'b0;
      bank_written_q <= '0;
    end else begin
      state_q        <= state_d;
      tag_bank_q     <= tag_bank_d;
      tag_addr_q     <= tag_addr_d;
      buf_q          <= buf_d;
      strb_q         <= strb_d;
      err_q          <= err_d;
      bank_written_q <= bank_written_d;
    end
  end

  // Output write port: strobe pulses one cycle, payload holds until next word.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      sram_we_q    <= 1'b0;
      sram_bank_q  <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wstrb_q <= '0;
    end else if (init) begin
      sram_we_q    <= 1'b0;
      sram_bank_q  <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wstrb_q <= '0;
    end else begin
      sram_we_q <= w_emit;
      if (w_emit) begin
        sram_bank_q  <= w_emit_bank;
        sram_addr_q  <= w_emit_addr;
        sram_wdata_q <= w_out_data;
        sram_wstrb_q <= w_out_strb;
      end
    end
  end

  assign sram_we_o      = sram_we_q;
  assign sram_bank_o    = sram_bank_q;
  assign sram_addr_o    = sram_addr_q;
  assign sram_wdata_o   = sram_wdata_q;
  assign sram_wstrb_o   = sram_wstrb_q;
  assign bank_written_o = bank_written_q;
  assign busy_o         = (state_q != ST_EMPTY);
  assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_sram_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_sram_packer
// Brief    : Scoreboard bench for weight_sram_packer (NUM_BANKS = 6 build).
//            Directed byte sequences push hand-computed words into a queue;
//            a monitor pops and compares on every sram_we_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_sram_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init;
  logic        we;
  logic [12:0] addr;
  logic [7:0]  data;
  logic [2:0]  dtype;
  logic        flush;

  logic        sram_we;
  logic [2:0]  sram_bank;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0]  sram_wstrb;
  logic [5:0]  bank_written;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  bank;
    logic [9:0]  addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  weight_sram_packer #(
    .DATA_WIDTH    (8),
    .PACK          (8),
    .MAX_ADDR_WIDTH(13),
    .NUM_BANKS     (6)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .init           (init),
    .write_enable_i (we),
    .write_address_i(addr),
    .write_data_i   (data),
    .data_type_i    (dtype),
    .flush_i        (flush),
    .sram_we_o      (sram_we),
    .sram_bank_o    (sram_bank),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_wstrb_o   (sram_wstrb),
    .bank_written_o (bank_written),
    .busy_o         (busy),
    .err_o          (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected emitted view of a word given its raw buffer and written lanes.
  function automatic logic [63:0] exp_data(input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = d;
`ifdef PACKER_ZERO_FILL_EN
    for (int k = 0; k < 8; k++) begin
      if (!s[k]) r[k*8 +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [7:0] s);
`ifdef PACKER_ZERO_FILL_EN
    return (s == 8'h00) ? 8'h00 : 8'hFF;
`else
    return s;
`endif
  endfunction

  task automatic expect_word(input logic [2:0] b, input logic [9:0] a,
                             input logic [63:0] d, input logic [7:0] s);
    exp_t e;
    e.bank = b;
    e.addr = a;
    e.data = exp_data(d, s);
    e.strb = exp_strb(s);
    sb.push_back(e);
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d, input logic [2:0] t, input logic f);
    we = 1'b1; addr = a; data = d; dtype = t; flush = f;
    @(posedge clk); #1;
    we = 1'b0; flush = 1'b0;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every write pulse must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sram_we === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_emit: got bank=%0d addr=%0d wdata=%h wstrb=%h expected no write",
                   sram_bank, sram_addr, sram_wdata, sram_wstrb);
        end else begin
          e = sb.pop_front();
          chk("emit_bank",  64'(sram_bank),  64'(e.bank));
          chk("emit_addr",  64'(sram_addr),  64'(e.addr));
          chk("emit_wdata", sram_wdata,      e.data);
          chk("emit_wstrb", 64'(sram_wstrb), 64'(e.strb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; init = 1'b0; we = 1'b0; addr = '0; data = '0; dtype = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_we",    64'(sram_we),      64'd0);
    chk("rst_wdata", sram_wdata,        64'd0);
    chk("rst_wstrb", 64'(sram_wstrb),   64'd0);
    chk("rst_flags", 64'(bank_written), 64'd0);
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_err",   64'(err),          64'd0);

    // Full word, bank 2: one emission after the eighth byte.
    expect_word(3'd2, 10'd0, 64'h0807060504030201, 8'hFF);
    for (int i = 0; i < 8; i++) wr(13'(i), 8'(i + 1), 3'd2, 1'b0);
    @(negedge clk);
    chk("t1_we_latency", 64'(sram_we),      64'd1);
    chk("t1_flags",      64'(bank_written), 64'b000010);
    chk("t1_busy",       64'(busy),         64'd0);
    idle(1);
    @(negedge clk);
    chk("t1_we_pulse",   64'(sram_we),      64'd0);

    // Address change within bank 1 closes word 0 as a partial word.
    expect_word(3'd1, 10'd0, 64'h0807060504131211, 8'h07);
    expect_word(3'd1, 10'd1, 64'h0807060504131221, 8'h01);
    wr(13'd0, 8'h11, 3'd1, 1'b0);
    wr(13'd1, 8'h12, 3'd1, 1'b0);
    wr(13'd2, 8'h13, 3'd1, 1'b0);
    wr(13'd8, 8'h21, 3'd1, 1'b0);
    @(negedge clk);
    chk("t2_busy_open", 64'(busy), 64'd1);
    flush_only();
    @(negedge clk);
    chk("t2_busy_done", 64'(busy), 64'd0);

    // Flush with a mismatching byte: two back-to-back emissions.
    expect_word(3'd3, 10'd0, 64'h0807353433131221, 8'h38);
    expect_word(3'd3, 10'd2, 64'h0807353433131240, 8'h01);
    wr(13'd3, 8'h33, 3'd3, 1'b0);
    wr(13'd4, 8'h34, 3'd3, 1'b0);
    wr(13'd5, 8'h35, 3'd3, 1'b0);
    wr(13'd16, 8'h40, 3'd3, 1'b1);
    @(negedge clk);
    chk("t3_busy_pend", 64'(busy), 64'd1);
    idle(1);
    @(negedge clk);
    chk("t3_we_second", 64'(sram_we), 64'd1);
    chk("t3_busy_done", 64'(busy),    64'd0);
    chk("t3_err_clear", 64'(err),     64'd0);

    // Lane rewrite inside an open word: last value wins, error sticks.
    expect_word(3'd4, 10'd0, 64'h0807355533131240, 8'h10);
    wr(13'd4, 8'hAA, 3'd4, 1'b0);
    wr(13'd4, 8'h55, 3'd4, 1'b0);
    flush_only();
    idle(2);
    @(negedge clk);
    chk("t4_err",   64'(err),          64'd1);
    chk("t4_flags", 64'(bank_written), 64'b001111);

    // Asynchronous reset in the middle of a word.
    wr(13'd0, 8'hC0, 3'd5, 1'b0);
    wr(13'd1, 8'hC1, 3'd5, 1'b0);
    wr(13'd2, 8'hC2, 3'd5, 1'b0);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_wdata", sram_wdata,        64'd0);
    chk("t5_rst_bank",  64'(sram_bank),    64'd0);
    chk("t5_rst_flags", 64'(bank_written), 64'd0);
    chk("t5_rst_busy",  64'(busy),         64'd0);
    chk("t5_rst_err",   64'(err),          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh full word after reset, then a single-byte flush into bank 6.
    expect_word(3'd5, 10'd1, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
    expect_word(3'd6, 10'd3, 64'hEEA6A5A4A3A2A1A0, 8'h80);
    for (int i = 0; i < 8; i++) wr(13'(8 + i), 8'(8'hA0 + i), 3'd5, 1'b0);
    wr(13'h1F, 8'hEE, 3'd6, 1'b1);
    @(negedge clk);
    chk("t6_we_immediate", 64'(sram_we),      64'd1);
    chk("t6_busy",         64'(busy),         64'd0);
    chk("t6_flags",        64'(bank_written), 64'b110000);

    // Discarded and out-of-range bank ids.
    wr(13'd0, 8'h99, 3'd0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t7_id0_err",  64'(err),  64'd0);
    chk("t7_id0_busy", 64'(busy), 64'd0);
    wr(13'd0, 8'h99, 3'd7, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t7_id7_err",  64'(err),  64'd1);
    chk("t7_id7_busy", 64'(busy), 64'd0);

    // Synchronous init clears flags and the held output word.
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    @(negedge clk);
    chk("t8_init_err",   64'(err),          64'd0);
    chk("t8_init_flags", 64'(bank_written), 64'd0);
    chk("t8_init_wdata", sram_wdata,        64'd0);
    chk("t8_init_wstrb", 64'(sram_wstrb),   64'd0);
    chk("t8_init_addr",  64'(sram_addr),    64'd0);

    idle(3);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
